xpb_seg_accum: RTL and testbench

XPB_SEG_ACCUM -- requirements
Module: xpb_seg_accum

---
 rtl/xpb_seg_accum.sv | 115 +++++++++++
 tb/tb_xpb_seg_accum.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/xpb_seg_accum.sv
// Segmented xpb reduction accumulator: sums NUM_SEG table responses, one segment per cycle.
// Optional macro XPB_SEG_ACCUM_PIPE_EN registers xpb_in ahead of the adder and adds a DRAIN state.
module xpb_seg_accum #(
    parameter int NUM_SEG = 8,
    parameter int SEG_W   = 5,
    parameter int XPB_W   = 1024,
    localparam int IDX_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    localparam int ACC_W  = XPB_W + $clog2(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_SEG*SEG_W-1:0] hi_word,
    output logic                     in_ready,
    output logic [SEG_W-1:0]         seg_data,
    output logic [IDX_W-1:0]         seg_idx,
    input  logic [XPB_W-1:0]         xpb_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
`ifdef XPB_SEG_ACCUM_PIPE_EN
        S_DRAIN,
`endif
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [NUM_SEG*SEG_W-1:0]   r_hi;
    logic [ACC_W-1:0]           r_acc;
    logic [IDX_W-1:0]           r_cnt;
    logic                       w_last;
    logic [ACC_W-1:0]           w_addend;

`ifdef XPB_SEG_ACCUM_PIPE_EN
    logic [XPB_W-1:0]           r_xpb;
    // The adder consumes last cycle's response; r_xpb is cleared at job start so the first add is zero.
    assign w_addend = ACC_W'(r_xpb);
`else
    assign w_addend = ACC_W'(xpb_in);
`endif

    assign w_last    = (r_cnt == IDX_W'(NUM_SEG - 1));
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_acc;
    assign seg_idx   = (r_state == S_ACCUM) ? r_cnt : '0;
    assign seg_data  = (r_state == S_ACCUM) ? r_hi[int'(r_cnt)*SEG_W +: SEG_W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef XPB_SEG_ACCUM_PIPE_EN
            r_xpb   <= '0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef XPB_SEG_ACCUM_PIPE_EN
            r_xpb   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi    <= hi_word;
                        r_acc   <= '0;
                        r_cnt   <= '0;
`ifdef XPB_SEG_ACCUM_PIPE_EN
                        r_xpb   <= '0;
`endif
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_addend;
`ifdef XPB_SEG_ACCUM_PIPE_EN
                    r_xpb <= xpb_in;
`endif
                    if (w_last) begin
`ifdef XPB_SEG_ACCUM_PIPE_EN
                        r_state <= S_DRAIN;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
`ifdef XPB_SEG_ACCUM_PIPE_EN
                S_DRAIN: begin
                    r_acc   <= r_acc + w_addend;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_seg_accum.sv
// Directed, table-driven bench for xpb_seg_accum at default parameters (either build of XPB_SEG_ACCUM_PIPE_EN).
module tb_xpb_seg_accum;

    localparam int NUM_SEG = 8;
    localparam int SEG_W   = 5;
    localparam int XPB_W   = 1024;
    localparam int IDX_W   = 3;
    localparam int ACC_W   = 1027;
    localparam int HW      = NUM_SEG * SEG_W;
`ifdef XPB_SEG_ACCUM_PIPE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [HW-1:0]    hi_word = '0;
    logic             in_ready;
    logic [SEG_W-1:0] seg_data;
    logic [IDX_W-1:0] seg_idx;
    logic [XPB_W-1:0] xpb_in;
    logic [XPB_W-1:0] tbl_echo;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic [1:0]       mode = 2'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External table: 0 = echo seg_data, 1 = all ones, 2 = echo shifted by 4*seg_idx
    always_comb begin
        tbl_echo = '0;
        tbl_echo[SEG_W-1:0] = seg_data;
        case (mode)
            2'd1:    xpb_in = '1;
            2'd2:    xpb_in = tbl_echo << (4 * int'(seg_idx));
            default: xpb_in = tbl_echo;
        endcase
    end

    xpb_seg_accum #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .XPB_W(XPB_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hi_word(hi_word), .in_ready(in_ready),
        .seg_data(seg_data), .seg_idx(seg_idx), .xpb_in(xpb_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act_top=%h act_low=%h exp_top=%h exp_low=%h",
                     nm, act[ACC_W-1 -: 64], act[63:0], exp[ACC_W-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic run_job(input logic [HW-1:0] hi, input logic [1:0] md,
                           input logic [ACC_W-1:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        mode = md; hi_word = hi; out_ready = 1'b1; start = 1'b1;
        chk($sformatf("%s.in_ready_idle", tag), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        hi_word = ~hi;
        chk($sformatf("%s.busy", tag), 64'(in_ready), 64'd0);
        chk($sformatf("%s.seg_idx0", tag), 64'(seg_idx), 64'd0);
        chk($sformatf("%s.seg_data0", tag), 64'(seg_data), 64'(hi[SEG_W-1:0]));
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("%s.latency", tag), 64'(cyc), 64'(LAT));
        chkw($sformatf("%s.out_data", tag), out_data, exp);
        @(posedge clk); #1;
        chk($sformatf("%s.valid_drop", tag), 64'(out_valid), 64'd0);
        chk($sformatf("%s.in_ready_back", tag), 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [HW-1:0]    hi;
        logic [1:0]       md;
        logic [ACC_W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [HW-1:0]    all1f;
        logic [HW-1:0]    one2eight;
        logic [ACC_W-1:0] big;
        logic             seen;
        int               cyc;

        all1f     = {8{5'h1F}};
        one2eight = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        big       = '1;
        big       = big - ACC_W'(7);

        vecs[0] = '{all1f, 2'd0, ACC_W'(64'hF8)};
        vecs[1] = '{all1f, 2'd1, big};
        vecs[2] = '{'0, 2'd0, '0};
        vecs[3] = '{one2eight, 2'd0, ACC_W'(64'd36)};
        vecs[4] = '{one2eight, 2'd2, ACC_W'(64'h87654321)};
        vecs[5] = '{all1f, 2'd2, ACC_W'(64'h21111110F)};
        vecs[6] = '{{4{5'h00, 5'h1F}}, 2'd0, ACC_W'(64'h7C)};

        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chkw("rst.out_data", out_data, '0);
        chk("rst.seg_data", 64'(seg_data), 64'd0);
        chk("rst.seg_idx", 64'(seg_idx), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].hi, vecs[i].md, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-pressure: result held while out_ready low, start pulses ignored
        @(negedge clk);
        mode = 2'd0; hi_word = '0; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold.latency", 64'(cyc), 64'(LAT));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b1; hi_word = all1f;
            chk($sformatf("hold%0d.valid", k), 64'(out_valid), 64'd1);
            chkw($sformatf("hold%0d.data", k), out_data, '0);
            chk($sformatf("hold%0d.in_ready", k), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("hold.still_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.release_valid", 64'(out_valid), 64'd0);
        chk("hold.release_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("hold.no_restart", 64'(in_ready), 64'd1);

        // Flush at T+4 together with start
        @(negedge clk);
        mode = 2'd0; hi_word = all1f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.seg_data", 64'(seg_data), 64'd0);
        chkw("flush.acc", out_data, '0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk("flush.stays_idle", 64'(seen), 64'd0);
        run_job(one2eight, 2'd0, ACC_W'(64'd36), "post_flush");

        // Asynchronous reset mid-ACCUM
        @(negedge clk);
        mode = 2'd0; hi_word = all1f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.seg_data", 64'(seg_data), 64'd0);
        chk("arst.seg_idx", 64'(seg_idx), 64'd0);
        chkw("arst.out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk("arst.no_spurious", 64'(seen), 64'd0);
        run_job(all1f, 2'd2, ACC_W'(64'h21111110F), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
